skewed_matrix_feeder: RTL and testbench

// Parametrised NxN operand feeder for the systolic array. Holds one NxN matrix in a

---
 rtl/skewed_matrix_feeder.sv | 172 +++++++++++++++++
 tb/tb_skewed_matrix_feeder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skewed_matrix_feeder.sv
// ----------------------------------------------------------------------------
// skewed_matrix_feeder
//
// Holds one NxN operand matrix in a local store and streams it into the edge
// of a systolic array as N skewed lanes. Lane k runs k cycles behind lane 0,
// so the wavefront enters the array diagonally. Each stream is one
// start/busy/done transaction.
//
// Feed modes:
//   transpose = 0 : lane k carries column k (mem[j*N + k], j = 0..N-1)
//   transpose = 1 : lane k carries row k    (mem[k*N + j], j = 0..N-1)
// The mode is sampled together with start and held for the whole stream.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (store contents are kept)
//   wr_en      store write strobe, honoured only while idle
//   wr_addr    row-major store address (r*N + c)
//   wr_data    store write data
//   start      begin one stream, honoured only while idle
//   transpose  feed mode, sampled with start
//   busy       a stream is in progress
//   done       one-cycle pulse coincident with the final beat
//   d          lane data, lane k at d[k*DW +: DW]; zero when not valid
//   valid      per-lane data-valid
// ----------------------------------------------------------------------------
module skewed_matrix_feeder #(
    parameter int N         = 4,
    parameter int DW        = 32,
    parameter int AW        = $clog2(N * N),
    parameter     INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    input  logic            transpose,
    output logic            busy,
    output logic            done,
    output logic [N*DW-1:0] d,
    output logic [N-1:0]    valid
);

    localparam int CW = $clog2(2 * N);
    // Last count value of a stream: lane N-1 issues element N-1 here.
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * N - 2);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic            mode_r;
    logic            mode_nxt_s;

    logic [DW-1:0]   mem_r [N*N];
    logic            addr_ok_s;
    logic            wr_commit_s;

    logic [N-1:0]    valid_r;
    logic [N-1:0]    valid_nxt_s;
    logic [N*DW-1:0] d_r;
    logic [N*DW-1:0] d_nxt_s;
    logic            done_r;
    logic            done_nxt_s;

    // When N*N fills the address space every address is legal, so no compare
    // is needed (and a constant-true compare would only draw lint noise).
    generate
        if (N * N == (1 << AW)) begin : g_addr_full
            assign addr_ok_s = 1'b1;
        end else begin : g_addr_part
            assign addr_ok_s = ({1'b0, wr_addr} < (AW + 1)'(N * N));
        end
    endgenerate

    // Writes are refused mid-stream so a running stream always sees one matrix.
    assign wr_commit_s = wr_en && (state_r == ST_IDLE) && addr_ok_s;

    // Operand store: deliberately not reset so a matrix survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Next-state logic for the IDLE/RUN sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mode_nxt_s  = mode_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                    mode_nxt_s  = transpose;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Lane datapath: lane k is k beats behind lane 0, so it issues element
    // j = cnt - k while that index lies inside the matrix.
    always_comb begin
        int j;
        valid_nxt_s = '0;
        d_nxt_s     = '0;
        done_nxt_s  = 1'b0;
        j           = 0;
        if (state_r == ST_RUN) begin
            done_nxt_s = (cnt_r == CNT_LAST);
            for (int k = 0; k < N; k++) begin
                j = int'(cnt_r) - k;
                if ((j >= 0) && (j < N)) begin
                    valid_nxt_s[k] = 1'b1;
                    d_nxt_s[k*DW +: DW] = mode_r ? mem_r[AW'(k * N + j)]
                                                 : mem_r[AW'(j * N + k)];
                end else begin
                    valid_nxt_s[k] = 1'b0;
                end
            end
        end else begin
            valid_nxt_s = '0;
        end
    end

    // Sequencer state and registered lane outputs; reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            mode_r  <= 1'b0;
            valid_r <= '0;
            d_r     <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            mode_r  <= mode_nxt_s;
            valid_r <= valid_nxt_s;
            d_r     <= d_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign busy  = (state_r == ST_RUN);
    assign done  = done_r;
    assign d     = d_r;
    assign valid = valid_r;

endmodule

// File: tb/tb_skewed_matrix_feeder.sv
// ----------------------------------------------------------------------------
// tb_skewed_matrix_feeder
//
// Directed bench for skewed_matrix_feeder with N=4, DW=32. The store is
// loaded with mem[a] = 0x100 + a. Edge e is counted from the edge that
// samples start (edge 0); outputs are sampled 1 ns after each rising edge.
// A beat-level reference (exp_d / exp_v) derives the expected lanes from a
// bench-side copy of the store; a few hand-written literals pin key beats.
// ----------------------------------------------------------------------------
module tb_skewed_matrix_feeder;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 4;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            transpose;
    logic            busy;
    logic            done;
    logic [N*DW-1:0] d;
    logic [N-1:0]    valid;

    logic [DW-1:0]   mm [N*N];
    int              checks;
    int              failures;

    skewed_matrix_feeder #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .transpose (transpose),
        .busy      (busy),
        .done      (done),
        .d         (d),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lane data 'rel' edges after the start-sampling edge.
    function automatic logic [N*DW-1:0] exp_d(input int rel, input bit tr);
        logic [N*DW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = rel - 1 - k;
            if (rel >= 1 && j >= 0 && j < N)
                r[k*DW +: DW] = tr ? mm[k*N + j] : mm[j*N + k];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_v(input int rel);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = rel - 1 - k;
            if (rel >= 1 && j >= 0 && j < N) r[k] = 1'b1;
        end
        return r;
    endfunction

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
        wr_en = 1'b1; wr_addr = a; wr_data = v;
        @(posedge clk); #1;
        wr_en = 1'b0;
        mm[a] = v;
    endtask

    // Drive start so that the next rising edge is edge 0 of a stream.
    task automatic kick(input bit tr);
        start = 1'b1; transpose = tr;
        @(posedge clk); #1;
        start = 1'b0; transpose = ~tr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; transpose = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || valid !== 4'h0 || d !== '0) begin
            failures++;
            $display("FAIL reset busy=%b done=%b valid=%h d=%h want all 0", busy, done, valid, d);
        end
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < N*N; a++) write_word(AW'(a), 32'h100 + 32'(a));
    endtask

    task automatic test_column();
        kick(1'b0);
        for (int e = 1; e <= 2*N; e++) begin
            @(posedge clk); #1;
            checks += 4;
            if (d !== exp_d(e, 1'b0)) begin
                failures++; $display("FAIL column_d e=%0d got=%h want=%h", e, d, exp_d(e, 1'b0));
            end
            if (valid !== exp_v(e)) begin
                failures++; $display("FAIL column_valid e=%0d got=%b want=%b", e, valid, exp_v(e));
            end
            if (done !== (e == 2*N-1)) begin
                failures++; $display("FAIL column_done e=%0d got=%b want=%b", e, done, (e == 2*N-1));
            end
            if (busy !== (e < 2*N-1)) begin
                failures++; $display("FAIL column_busy e=%0d got=%b want=%b", e, busy, (e < 2*N-1));
            end
            if (e == 1) begin
                checks++;
                if (d[31:0] !== 32'h100) begin
                    failures++; $display("FAIL column_lane0_first got=%h want=00000100", d[31:0]);
                end
            end
            if (e == 7) begin
                checks++;
                if (d[127:96] !== 32'h10F) begin
                    failures++; $display("FAIL column_lane3_last got=%h want=0000010f", d[127:96]);
                end
            end
        end
    endtask

    task automatic test_row();
        kick(1'b1);
        for (int e = 1; e <= 2*N; e++) begin
            @(posedge clk); #1;
            checks += 3;
            if (d !== exp_d(e, 1'b1)) begin
                failures++; $display("FAIL row_d e=%0d got=%h want=%h", e, d, exp_d(e, 1'b1));
            end
            if (valid !== exp_v(e)) begin
                failures++; $display("FAIL row_valid e=%0d got=%b want=%b", e, valid, exp_v(e));
            end
            if (done !== (e == 2*N-1)) begin
                failures++; $display("FAIL row_done e=%0d got=%b want=%b", e, done, (e == 2*N-1));
            end
            if (e == 2) begin
                checks++;
                if (d[63:32] !== 32'h104) begin
                    failures++; $display("FAIL row_lane1_first got=%h want=00000104", d[63:32]);
                end
            end
            if (e == 5) begin
                checks++;
                if (d[63:32] !== 32'h107) begin
                    failures++; $display("FAIL row_lane1_last got=%h want=00000107", d[63:32]);
                end
            end
        end
    endtask

    // Start and a store write mid-stream are both ignored; afterwards an idle
    // write issued together with start must be seen by that same stream.
    // With N=4 the 4-bit wr_addr cannot express an out-of-range address.
    task automatic test_busy_guards();
        kick(1'b0);
        for (int e = 1; e <= 2*N+1; e++) begin
            if (e == 3) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h0000DEAD;
            end
            @(posedge clk); #1;
            if (e == 3) begin
                start = 1'b0; wr_en = 1'b0;
            end
            checks += 3;
            if (d !== exp_d(e, 1'b0)) begin
                failures++; $display("FAIL guard_d e=%0d got=%h want=%h", e, d, exp_d(e, 1'b0));
            end
            if (valid !== exp_v(e)) begin
                failures++; $display("FAIL guard_valid e=%0d got=%b want=%b", e, valid, exp_v(e));
            end
            if (busy !== (e < 2*N-1)) begin
                failures++; $display("FAIL guard_busy e=%0d got=%b want=%b", e, busy, (e < 2*N-1));
            end
        end
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h000005A5;
        mm[5] = 32'h000005A5;
        kick(1'b0);
        wr_en = 1'b0;
        for (int e = 1; e <= 2*N; e++) begin
            @(posedge clk); #1;
            checks++;
            if (d !== exp_d(e, 1'b0)) begin
                failures++; $display("FAIL wrstart_d e=%0d got=%h want=%h", e, d, exp_d(e, 1'b0));
            end
            if (e == 1) begin
                checks++;
                if (d[31:0] !== 32'h100) begin
                    failures++; $display("FAIL guard_mem0 got=%h want=00000100", d[31:0]);
                end
            end
            if (e == 3) begin
                checks++;
                if (d[63:32] !== 32'h5A5) begin
                    failures++; $display("FAIL wrstart_lane1 got=%h want=000005a5", d[63:32]);
                end
            end
        end
        write_word(4'd5, 32'h105);
    endtask

    task automatic test_mid_reset();
        kick(1'b0);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || valid !== 4'h0 || d !== '0) begin
            failures++;
            $display("FAIL midreset busy=%b done=%b valid=%h d=%h want all 0", busy, done, valid, d);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL midreset_idle busy=%b want=0", busy);
        end
        kick(1'b0);
        for (int e = 1; e <= 2*N; e++) begin
            @(posedge clk); #1;
            checks += 3;
            if (d !== exp_d(e, 1'b0)) begin
                failures++; $display("FAIL replay_d e=%0d got=%h want=%h", e, d, exp_d(e, 1'b0));
            end
            if (valid !== exp_v(e)) begin
                failures++; $display("FAIL replay_valid e=%0d got=%b want=%b", e, valid, exp_v(e));
            end
            if (done !== (e == 2*N-1)) begin
                failures++; $display("FAIL replay_done e=%0d got=%b want=%b", e, done, (e == 2*N-1));
            end
        end
    endtask

    // start held high: the second stream is accepted on the edge after done,
    // leaving one all-zero bubble beat (edge 8) between the streams.
    task automatic test_back_to_back();
        start = 1'b1; transpose = 1'b0;
        @(posedge clk); #1;
        for (int e = 1; e <= 16; e++) begin
            int rel;
            @(posedge clk); #1;
            rel = (e <= 7) ? e : e - 8;
            checks += 4;
            if (d !== exp_d(rel, 1'b0)) begin
                failures++; $display("FAIL b2b_d e=%0d got=%h want=%h", e, d, exp_d(rel, 1'b0));
            end
            if (valid !== exp_v(rel)) begin
                failures++; $display("FAIL b2b_valid e=%0d got=%b want=%b", e, valid, exp_v(rel));
            end
            if (done !== (rel == 2*N-1)) begin
                failures++; $display("FAIL b2b_done e=%0d got=%b want=%b", e, done, (rel == 2*N-1));
            end
            if (busy !== (rel < 2*N-1)) begin
                failures++; $display("FAIL b2b_busy e=%0d got=%b want=%b", e, busy, (rel < 2*N-1));
            end
            if (e == 9) begin
                checks++;
                if (d[31:0] !== 32'h100) begin
                    failures++; $display("FAIL b2b_second_lane0 got=%h want=00000100", d[31:0]);
                end
            end
            if (e == 15) start = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_column();
        test_row();
        test_busy_guards();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
